// File: rtl/uart_str_sender.sv
// Sends a latched ASCII string one byte at a time to a UART frame transmitter.
// The string can be followed by CR/LF, with optional idle gaps between bytes.
module uart_str_sender #(
  parameter int MAX_LEN     = 32,
  parameter int LEN_W       = 6,
  parameter int APPEND_CRLF = 0,
  parameter int GAP_CYCLES  = 0
) (
  input  logic                 clk,
  input  logic                 reset_p,
  input  logic                 start,
  input  logic [8*MAX_LEN-1:0] str,
  input  logic [LEN_W-1:0]     str_len,
  input  logic                 abort,
  input  logic                 tx_done,
  output logic [7:0]           char,
  output logic                 tx_en,
  output logic                 busy,
  output logic                 done,
  output logic                 err_len
);

  localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [LEN_W:0]   TAIL_N   = (APPEND_CRLF != 0) ? (LEN_W+1)'(2) : '0;
  localparam logic [LEN_W:0]   MAX_N    = (LEN_W+1)'(MAX_LEN);
  localparam logic [LEN_W:0]   ONE      = (LEN_W+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_GAP} state_t;

  state_t               state_q;
  logic [8*MAX_LEN-1:0] str_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W:0]       idx_q;
  logic [GAP_W-1:0]     gap_q;
  logic [7:0]           char_q;
  logic                 tx_en_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_len_q;

  logic [LEN_W:0]       total_bytes;
  logic [LEN_W:0]       sel_pos;
  logic [7:0]           send_byte;
  logic                 last_byte;

  // idx_q counts bytes already handed off; it reaching the total means the message is complete.
  always_comb begin
    total_bytes = {1'b0, len_q} + TAIL_N;
    last_byte   = (idx_q == total_bytes);
    sel_pos     = {1'b0, len_q} - idx_q - ONE;
    send_byte   = 8'h00;
    if (idx_q < {1'b0, len_q}) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        if ((LEN_W+1)'(k) == sel_pos) begin
          send_byte = str_q[8*k +: 8];
        end
      end
    end else if (idx_q == {1'b0, len_q}) begin
      send_byte = 8'h0D;
    end else begin
      send_byte = 8'h0A;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q   <= S_IDLE;
      str_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      gap_q     <= '0;
      char_q    <= 8'h00;
      tx_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      tx_en_q   <= 1'b0;
      done_q    <= 1'b0;
      err_len_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            if ({1'b0, str_len} > MAX_N) begin
              err_len_q <= 1'b1;
            end else begin
              str_q   <= str;
              len_q   <= str_len;
              idx_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (last_byte) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            char_q  <= send_byte;
            tx_en_q <= 1'b1;
            idx_q   <= idx_q + ONE;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A tx_done coinciding with our own tx_en belongs to an earlier frame.
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (tx_done && !tx_en_q) begin
            if (last_byte) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else if (GAP_CYCLES > 0) begin
              gap_q   <= GAP_LOAD;
              state_q <= S_GAP;
            end else begin
              char_q  <= send_byte;
              tx_en_q <= 1'b1;
              idx_q   <= idx_q + ONE;
              state_q <= S_WAIT;
            end
          end
        end
        S_GAP: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (gap_q == '0) begin
            char_q  <= send_byte;
            tx_en_q <= 1'b1;
            idx_q   <= idx_q + ONE;
            state_q <= S_WAIT;
          end else begin
            gap_q <= gap_q - GAP_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign char    = char_q;
  assign tx_en   = tx_en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err_len = err_len_q;

endmodule

// File: tb/tb_uart_str_sender.sv
// Directed bench for uart_str_sender: three instances (plain, CR/LF, 5-cycle gap)
// each driven by a frame-transmitter model that answers tx_en with tx_done 10 cycles later.
module tb_uart_str_sender;

  localparam int ML = 32;

  logic            clk;
  logic            reset_p;
  logic [2:0]      start_r;
  logic [2:0]      abort_r;
  logic [8*ML-1:0] str_r;
  logic [5:0]      len_r;
  logic [2:0]      tx_done_r;
  logic [7:0]      char_w [3];
  logic [2:0]      tx_en_w, busy_w, done_w, err_w;

  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;
  int exp_space [3];
  int cd [3];
  int n_en [3];
  int n_done [3];
  logic [7:0] log_char [3][128];
  int en_cyc [3][128];
  int resp_cyc [3][128];

  typedef struct {
    int               k;
    logic [255:0]     s;
    int               len;
    logic [271:0]     ex;
    int               n;
  } vec_t;
  vec_t vecs [5];

  uart_str_sender #(.MAX_LEN(ML), .LEN_W(6), .APPEND_CRLF(0), .GAP_CYCLES(0)) u0 (
    .clk(clk), .reset_p(reset_p), .start(start_r[0]), .str(str_r), .str_len(len_r),
    .abort(abort_r[0]), .tx_done(tx_done_r[0]), .char(char_w[0]), .tx_en(tx_en_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .err_len(err_w[0]));
  uart_str_sender #(.MAX_LEN(ML), .LEN_W(6), .APPEND_CRLF(1), .GAP_CYCLES(0)) u1 (
    .clk(clk), .reset_p(reset_p), .start(start_r[1]), .str(str_r), .str_len(len_r),
    .abort(abort_r[1]), .tx_done(tx_done_r[1]), .char(char_w[1]), .tx_en(tx_en_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .err_len(err_w[1]));
  uart_str_sender #(.MAX_LEN(ML), .LEN_W(6), .APPEND_CRLF(0), .GAP_CYCLES(5)) u2 (
    .clk(clk), .reset_p(reset_p), .start(start_r[2]), .str(str_r), .str_len(len_r),
    .abort(abort_r[2]), .tx_done(tx_done_r[2]), .char(char_w[2]), .tx_en(tx_en_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .err_len(err_w[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Frame transmitter model and logger, sampling on the falling edge.
  initial begin
    for (int k = 0; k < 3; k++) begin
      cd[k] = 0; n_en[k] = 0; n_done[k] = 0;
    end
    tx_done_r = 3'b000;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        tx_done_r[k] = 1'b0;
        if (cd[k] > 0) begin
          cd[k]--;
          if (cd[k] == 0) begin
            tx_done_r[k] = 1'b1;
            if (n_en[k] > 0 && n_en[k] <= 128) resp_cyc[k][n_en[k]-1] = cyc;
          end
        end
        if (tx_en_w[k] === 1'b1) begin
          if (n_en[k] < 128) begin
            log_char[k][n_en[k]] = char_w[k];
            en_cyc[k][n_en[k]]   = cyc;
          end
          n_en[k]++;
          cd[k] = 10;
        end
        if (done_w[k] === 1'b1) n_done[k]++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input int k);
    @(negedge clk);
    start_r[k] = 1'b1;
    @(negedge clk);
    start_r[k] = 1'b0;
  endtask

  task automatic run_msg(input int k, input logic [255:0] s, input int len,
                         input logic [271:0] ex, input int n);
    int base, base_d, start_c, done_c, busy_low, t, bad;
    logic got;
    base = n_en[k]; base_d = n_done[k];
    str_r = s; len_r = 6'(len);
    @(negedge clk);
    start_r[k] = 1'b1;
    start_c = cyc;
    @(negedge clk);
    start_r[k] = 1'b0;
    got = 1'b0; busy_low = 0; t = 0; done_c = 0;
    while (!got && t < 3000) begin
      if (done_w[k] === 1'b1) begin
        got = 1'b1;
        done_c = cyc;
      end else begin
        if (busy_w[k] !== 1'b1) busy_low++;
        @(negedge clk);
        t++;
      end
    end
    check("done_seen", got, 1);
    check("busy_at_done", busy_w[k], 0);
    check("busy_held", busy_low, 0);
    check("byte_count", n_en[k] - base, n);
    for (int j = 0; j < n; j++) begin
      check("byte_value", log_char[k][base+j], ex[8*(n-1-j) +: 8]);
    end
    if (n > 0) begin
      check("first_tx_en_latency", en_cyc[k][base] - start_c, 2);
      check("done_latency", done_c - resp_cyc[k][base+n-1], 1);
      bad = 0;
      for (int j = 1; j < n; j++) begin
        if (en_cyc[k][base+j] - resp_cyc[k][base+j-1] != exp_space[k]) bad++;
      end
      check("tx_en_spacing", bad, 0);
    end else begin
      check("empty_done_latency", done_c - start_c, 2);
    end
    @(negedge clk);
    check("done_one_cycle", done_w[k], 0);
    check("done_count", n_done[k] - base_d, 1);
    $display("msg inst=%0d len=%0d bytes=%0d done_at=%0d", k, len, n_en[k] - base, done_c);
  endtask

  initial begin
    int base, extra, seen, t;
    exp_space[0] = 1; exp_space[1] = 1; exp_space[2] = 6;
    vecs[0] = '{0, 256'("ABC"), 3, 272'("ABC"), 3};
    vecs[1] = '{1, 256'("HI"), 2, 272'({"HI", 8'h0D, 8'h0A}), 4};
    vecs[2] = '{1, 256'(0), 0, 272'(16'h0D0A), 2};
    vecs[3] = '{2, 256'("ABCDEFGHIJKLMNOPQRSTUVWXYZ789012"), 32,
                272'("ABCDEFGHIJKLMNOPQRSTUVWXYZ789012"), 32};
    vecs[4] = '{0, 256'(0), 0, 272'(0), 0};

    reset_p = 1'b1; start_r = '0; abort_r = '0; str_r = '0; len_r = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_char", char_w[k], 0);
      check("reset_tx_en", tx_en_w[k], 0);
      check("reset_busy", busy_w[k], 0);
      check("reset_done", done_w[k], 0);
      check("reset_err_len", err_w[k], 0);
    end
    reset_p = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      run_msg(vecs[v].k, vecs[v].s, vecs[v].len, vecs[v].ex, vecs[v].n);
    end

    // Oversized length is rejected with a single err_len pulse.
    base = n_en[0];
    str_r = 256'("ABC"); len_r = 6'd40;
    pulse_start(0);
    check("err_len_pulse", err_w[0], 1);
    check("err_busy", busy_w[0], 0);
    check("err_tx_en", tx_en_w[0], 0);
    @(negedge clk);
    check("err_len_one_cycle", err_w[0], 0);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_en_w[0] || busy_w[0] || done_w[0] || err_w[0]) extra++;
    end
    check("err_quiet", extra, 0);
    check("err_no_bytes", n_en[0] - base, 0);
    run_msg(0, 256'("ABC"), 3, 272'("ABC"), 3);

    // Abort 3 cycles after the second tx_en.
    base = n_en[0];
    str_r = 256'("ABCDEF"); len_r = 6'd6;
    pulse_start(0);
    seen = 0; t = 0;
    while (seen < 2 && t < 200) begin
      @(negedge clk);
      t++;
      if (tx_en_w[0]) seen++;
    end
    check("abort_setup", seen, 2);
    repeat (3) @(negedge clk);
    abort_r[0] = 1'b1;
    @(negedge clk);
    abort_r[0] = 1'b0;
    check("abort_busy", busy_w[0], 0);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_en_w[0] || busy_w[0] || done_w[0]) extra++;
    end
    check("abort_quiet", extra, 0);
    check("abort_bytes", n_en[0] - base, 2);
    run_msg(0, 256'("ABC"), 3, 272'("ABC"), 3);

    // Start while busy is dropped; the latched string is unaffected.
    base = n_en[0];
    str_r = 256'("XY"); len_r = 6'd2;
    pulse_start(0);
    repeat (5) @(negedge clk);
    str_r = 256'("QQQ"); len_r = 6'd3;
    pulse_start(0);
    t = 0;
    while (done_w[0] !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("busy_start_done", done_w[0], 1);
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx_en_w[0] || busy_w[0]) extra++;
    end
    check("busy_start_quiet", extra, 0);
    check("busy_start_bytes", n_en[0] - base, 2);
    check("busy_start_b0", log_char[0][base], 8'h58);
    check("busy_start_b1", log_char[0][base+1], 8'h59);

    // Reset in the middle of a message.
    base = n_en[0];
    str_r = 256'("ABCDE"); len_r = 6'd5;
    pulse_start(0);
    seen = 0; t = 0;
    while (seen < 2 && t < 200) begin
      @(negedge clk);
      t++;
      if (tx_en_w[0]) seen++;
    end
    repeat (2) @(negedge clk);
    reset_p = 1'b1;
    #1;
    check("midrst_char", char_w[0], 0);
    check("midrst_tx_en", tx_en_w[0], 0);
    check("midrst_busy", busy_w[0], 0);
    check("midrst_done", done_w[0], 0);
    check("midrst_err_len", err_w[0], 0);
    repeat (2) @(negedge clk);
    reset_p = 1'b0;
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx_en_w[0] || busy_w[0] || done_w[0]) extra++;
    end
    check("midrst_quiet", extra, 0);
    check("midrst_bytes", n_en[0] - base, 2);
    run_msg(0, 256'("ABC"), 3, 272'("ABC"), 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_str_sender.md
Name: uart_str_sender

Overview:
Parametrised string-to-byte sequencer. It sits between string producers (LCD/status/debug logic) and the UART frame transmitter (uart_frame_tx: frame_en/data_frame in, tx_done out).
- Captures a packed ASCII string of up to MAX_LEN characters.
- Feeds the string one byte at a time under a strict pulse/done handshake.
- Optionally appends CR/LF and inserts programmable inter-byte gaps.
- Reports busy, completion and length errors, and supports abort.
- Runs on a single clock edge throughout.

Parameters:
MAX_LEN, 32, maximum characters per message; must be >= 1.
LEN_W, 6, width of str_len; must satisfy 2^LEN_W > MAX_LEN.
APPEND_CRLF, 0, 1 = send 8'h0D then 8'h0A after the last string character.
GAP_CYCLES, 0, idle clk cycles inserted after each tx_done before the next tx_en; 0 means no gap.

Ports:
clk  in  1  system clock; all logic on posedge.
reset_p  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request to send; sampled only in IDLE.
str  in  8*MAX_LEN  packed string, Verilog-literal order: first char at str[8*str_len-1 -: 8], last char at str[7:0].
str_len  in  LEN_W  number of characters, 0..MAX_LEN.
abort  in  1  cancel the current message.
tx_done  in  1  one-cycle pulse from frame transmitter: byte finished.
char  out  8  byte to transmit; registered.
tx_en  out  1  one-cycle pulse: char valid, start frame.
busy  out  1  high from acceptance until completion or abort.
done  out  1  one-cycle pulse: message fully sent.
err_len  out  1  one-cycle pulse: start rejected because str_len > MAX_LEN.

Behaviour:
- Reset: all outputs 0, char = 8'h00, state IDLE, buffer and index cleared. Reset mid-message: immediate return to IDLE; no done.

States:
- IDLE: on start with str_len <= MAX_LEN:
  - Latch str and str_len into an internal buffer; later changes to str/str_len are ignored.
  - busy = 1 from the next edge.
  - If str_len > MAX_LEN: err_len pulses on the next edge, busy stays 0, no tx_en.
- LOAD: the edge after acceptance drives char = first byte and tx_en = 1 for that one cycle. This is the SEND action, so the first tx_en appears 1 cycle after start is sampled.
- WAIT: char is held stable and tx_en = 0. tx_done is sampled only in WAIT; a tx_done in the tx_en cycle or in IDLE/GAP is ignored. On tx_done:
  - go to GAP if GAP_CYCLES > 0, otherwise go to the next SEND;
  - the next tx_en occurs 1 cycle after tx_done when GAP_CYCLES = 0.
- GAP: counts exactly GAP_CYCLES cycles, then issues the next SEND.
- Byte sequence: str_len string bytes, then 0x0D and 0x0A if APPEND_CRLF = 1, each using the same handshake.
- str_len = 0: with APPEND_CRLF, only CR and LF are sent. Without it, done pulses 1 cycle after start, busy is high for exactly that one cycle, and no tx_en is issued.
- Completion: on the tx_done of the final byte, the next edge asserts done = 1 for one cycle and busy = 0 on that same edge. The machine returns to IDLE and accepts start on that cycle's edge.
- start while busy: ignored; not queued, no error.
- abort: effective in any non-IDLE state on the next edge.
  - Go to IDLE; busy = 0, tx_en = 0, no done.
  - A frame already handed off completes in the transmitter; its tx_done is ignored.
  - abort and start in the same cycle: abort wins and start is dropped.
- Index counter: width LEN_W+1 to cover the CR/LF tail; no wrap inside a message.
- Byte select: buf[8*(len-1-i) +: 8].

Test Plan:
- MAX_LEN=32, APPEND_CRLF=0, GAP_CYCLES=0, str="ABC", str_len=3, tx_done model 10 cycles after tx_en -> exactly 3 tx_en pulses with char 0x41, 0x42, 0x43; each next tx_en 1 cycle after tx_done; done 1 cycle after third tx_done; busy high throughout.
- APPEND_CRLF=1, str="HI", str_len=2 -> char 0x48, 0x49, 0x0D, 0x0A, then done. With str_len=0 -> only 0x0D, 0x0A.
- str_len=40 with MAX_LEN=32 -> err_len single pulse next cycle; busy, tx_en, done stay 0. A following valid start is accepted normally.
- 32-char str "ABCDEFGHIJKLMNOPQRSTUVWXYZ789012", GAP_CYCLES=5 -> 32 bytes in order, first 0x41 and last 0x32; each tx_en exactly 6 cycles after the preceding tx_done.
- abort asserted 3 cycles after the second tx_en -> busy 0 next edge; no further tx_en; no done; a late tx_done is ignored; a new start sends from the first character.
- start pulsed while busy, and reset_p asserted mid-message -> no extra bytes or queued message; after reset all outputs 0 and IDLE.
